// File: rtl/pwf_multi.sv
// Multi-channel pulse-width filter: synchronises slow asynchronous inputs and qualifies each
// level change over a run of consecutive samples before it reaches the clk11m control logic.
module pwf_multi #(
    parameter int CH          = 4,
    parameter int CNT_W       = 4,
    parameter int HI_CNT      = 12,
    parameter int LO_CNT      = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk11m,
    input  logic          rst_n,
    input  logic          en,
    input  logic [CH-1:0] g,
    output logic [CH-1:0] i,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall
);

    typedef enum logic [1:0] {LOW, QUAL_HI, HIGH, QUAL_LO} state_t;

    localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(HI_CNT - 1);
    localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(LO_CNT - 1);

    if (HI_CNT < 1 || HI_CNT >= 2**CNT_W) begin : g_bad_hi_cnt
        $error("pwf_multi: HI_CNT must be in 1..2**CNT_W-1");
    end
    if (LO_CNT < 1 || LO_CNT >= 2**CNT_W) begin : g_bad_lo_cnt
        $error("pwf_multi: LO_CNT must be in 1..2**CNT_W-1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("pwf_multi: SYNC_STAGES must be at least 2");
    end

    logic [CH-1:0][SYNC_STAGES-1:0] sync_q;
    logic [CH-1:0]                  gs;
    state_t                         state [CH];
    logic [CNT_W-1:0]               cnt   [CH];

    // NOTE: every flop here, including the synchroniser chain, is cleared by the async reset so
    // the outputs read 0 immediately and the first post-reset edge starts from a known history.
    always_ff @(posedge clk11m or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            for (int k = 0; k < CH; k++) begin
                sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], g[k]};
            end
        end
    end

    always_comb begin
        gs = '0;
        for (int k = 0; k < CH; k++) begin
            gs[k] = sync_q[k][SYNC_STAGES-1];
        end
    end

    // NOTE: state is updated with non-blocking assignments so every channel in the loop sees the
    // pre-edge values; blocking here would create order-dependent simulation results.
    always_ff @(posedge clk11m or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CH; k++) begin
                state[k] <= LOW;
                cnt[k]   <= '0;
            end
            i    <= '0;
            rise <= '0;
            fall <= '0;
        end else begin
            for (int k = 0; k < CH; k++) begin
                rise[k] <= 1'b0;
                fall[k] <= 1'b0;
                if (!en) begin
                    cnt[k]   <= '0;
                    state[k] <= i[k] ? HIGH : LOW;
                end else begin
                    case (state[k])
                        LOW: begin
                            if (gs[k]) begin
                                if (HI_CNT == 1) begin
                                    i[k]     <= 1'b1;
                                    rise[k]  <= 1'b1;
                                    state[k] <= HIGH;
                                end else begin
                                    cnt[k]   <= CNT_W'(1);
                                    state[k] <= QUAL_HI;
                                end
                            end
                        end
                        QUAL_HI: begin
                            if (!gs[k]) begin
                                cnt[k]   <= '0;
                                state[k] <= LOW;
                            end else if (cnt[k] == HI_LAST) begin
                                i[k]     <= 1'b1;
                                rise[k]  <= 1'b1;
                                cnt[k]   <= '0;
                                state[k] <= HIGH;
                            end else begin
                                cnt[k] <= cnt[k] + 1'b1;
                            end
                        end
                        HIGH: begin
                            if (!gs[k]) begin
                                if (LO_CNT == 1) begin
                                    i[k]     <= 1'b0;
                                    fall[k]  <= 1'b1;
                                    state[k] <= LOW;
                                end else begin
                                    cnt[k]   <= CNT_W'(1);
                                    state[k] <= QUAL_LO;
                                end
                            end
                        end
                        QUAL_LO: begin
                            if (gs[k]) begin
                                cnt[k]   <= '0;
                                state[k] <= HIGH;
                            end else if (cnt[k] == LO_LAST) begin
                                i[k]     <= 1'b0;
                                fall[k]  <= 1'b1;
                                cnt[k]   <= '0;
                                state[k] <= LOW;
                            end else begin
                                cnt[k] <= cnt[k] + 1'b1;
                            end
                        end
                        default: begin
                            cnt[k]   <= '0;
                            state[k] <= i[k] ? HIGH : LOW;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pwf_multi.sv
// Bench for pwf_multi: directed vectors plus randomized stimulus against a run-length model,
// covering a LO_CNT=1 instance and a LO_CNT=3 instance side by side.
module tb_pwf_multi;

    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int HI   = 12;

    logic          clk11m = 1'b0;
    logic          rst_n  = 1'b1;
    logic          en     = 1'b1;
    logic [CH-1:0] g      = '0;
    logic [CH-1:0] i0, rise0, fall0;
    logic [CH-1:0] i1, rise1, fall1;

    int checks = 0;
    int errors = 0;

    always #45 clk11m = ~clk11m;

    pwf_multi #(.CH(CH), .CNT_W(4), .HI_CNT(HI), .LO_CNT(1), .SYNC_STAGES(SYNC)) dut0 (
        .clk11m(clk11m), .rst_n(rst_n), .en(en), .g(g),
        .i(i0), .rise(rise0), .fall(fall0)
    );

    pwf_multi #(.CH(CH), .CNT_W(4), .HI_CNT(HI), .LO_CNT(3), .SYNC_STAGES(SYNC)) dut1 (
        .clk11m(clk11m), .rst_n(rst_n), .en(en), .g(g),
        .i(i1), .rise(rise1), .fall(fall1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk11m);
    endtask

    // Reference model: g is delayed SYNC edges, then each output flips once the number of
    // consecutive enabled samples that disagree with it reaches the threshold for that direction.
    int            lo_need [2] = '{1, 3};
    logic [CH-1:0] m_i     [2] = '{'0, '0};
    logic [CH-1:0] m_rise  [2] = '{'0, '0};
    logic [CH-1:0] m_fall  [2] = '{'0, '0};
    int            m_run   [2][CH];
    logic [CH-1:0] m_gq    [$];
    logic [CH-1:0] m_gs;

    always @(posedge clk11m or negedge rst_n) begin
        if (!rst_n) begin
            m_gq = {};
            repeat (SYNC) m_gq.push_back('0);
            for (int c = 0; c < 2; c++) begin
                m_i[c] = '0; m_rise[c] = '0; m_fall[c] = '0;
                for (int k = 0; k < CH; k++) m_run[c][k] = 0;
            end
        end else begin
            m_gs = m_gq.pop_front();
            m_gq.push_back(g);
            for (int c = 0; c < 2; c++) begin
                m_rise[c] = '0;
                m_fall[c] = '0;
                for (int k = 0; k < CH; k++) begin
                    if (!en || m_gs[k] == m_i[c][k]) begin
                        m_run[c][k] = 0;
                    end else begin
                        m_run[c][k]++;
                        if (m_run[c][k] == (m_i[c][k] ? lo_need[c] : HI)) begin
                            m_i[c][k] = ~m_i[c][k];
                            if (m_i[c][k]) m_rise[c][k] = 1'b1;
                            else           m_fall[c][k] = 1'b1;
                            m_run[c][k] = 0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk11m) begin
        check("sb_dut0", {20'h0, i0, rise0, fall0}, {20'h0, m_i[0], m_rise[0], m_fall[0]});
        check("sb_dut1", {20'h0, i1, rise1, fall1}, {20'h0, m_i[1], m_rise[1], m_fall[1]});
    end

    typedef struct {
        logic [CH-1:0] g;
        logic          en;
        int            hold;
        logic [CH-1:0] exp_i;
        logic [CH-1:0] exp_rise;
        logic [CH-1:0] exp_fall;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int rate;

        // Glitch rejection, en freeze and release timing on ch0 of the LO_CNT=1 instance.
        vecs[0]  = '{4'h1, 1'b1, 11, 4'h0, 4'h0, 4'h0};
        vecs[1]  = '{4'h0, 1'b1,  1, 4'h0, 4'h0, 4'h0};
        vecs[2]  = '{4'h1, 1'b1, 13, 4'h0, 4'h0, 4'h0};
        vecs[3]  = '{4'h1, 1'b1,  1, 4'h1, 4'h1, 4'h0};
        vecs[4]  = '{4'h1, 1'b1,  1, 4'h1, 4'h0, 4'h0};
        vecs[5]  = '{4'h1, 1'b1,  5, 4'h1, 4'h0, 4'h0};
        vecs[6]  = '{4'h0, 1'b1,  3, 4'h0, 4'h0, 4'h1};
        vecs[7]  = '{4'h0, 1'b1,  1, 4'h0, 4'h0, 4'h0};
        vecs[8]  = '{4'h1, 1'b1, 10, 4'h0, 4'h0, 4'h0};
        vecs[9]  = '{4'h1, 1'b0,  5, 4'h0, 4'h0, 4'h0};
        vecs[10] = '{4'h1, 1'b1, 11, 4'h0, 4'h0, 4'h0};
        vecs[11] = '{4'h1, 1'b1,  1, 4'h1, 4'h1, 4'h0};
        vecs[12] = '{4'h1, 1'b1,  1, 4'h1, 4'h0, 4'h0};
        vecs[13] = '{4'h0, 1'b0,  6, 4'h1, 4'h0, 4'h0};
        vecs[14] = '{4'h0, 1'b1,  1, 4'h0, 4'h0, 4'h1};
        vecs[15] = '{4'h0, 1'b1,  1, 4'h0, 4'h0, 4'h0};

        // Reset with all inputs high, then release.
        g = 4'hF;
        #1 rst_n = 1'b0;
        tick(3);
        check("rst_outputs", {20'h0, i0, rise0, fall0}, 32'h0);
        rst_n = 1'b1;
        tick(13);
        check("t1_before", {28'h0, i0}, 32'h0);
        tick(1);
        check("t1_rise", {24'h0, i0, rise0}, 32'hFF);
        tick(1);
        check("t1_rise_clr", {24'h0, i0, rise0}, 32'hF0);

        // LO_CNT=3 instance: a two-sample low is ignored, a three-sample low releases.
        g = 4'hD;
        for (int n = 0; n < 2; n++) begin
            tick(1);
            check("t3_nofall", {31'h0, fall1[1]}, 32'h0);
        end
        g = 4'hF;
        for (int n = 0; n < 6; n++) begin
            tick(1);
            check("t3_nofall", {31'h0, fall1[1]}, 32'h0);
        end
        check("t3_hold", {31'h0, i1[1]}, 32'h1);
        g = 4'hD;
        tick(4);
        check("t3_fall_early", {30'h0, i1[1], fall1[1]}, 32'h2);
        tick(1);
        check("t3_fall", {30'h0, i1[1], fall1[1]}, 32'h1);
        tick(1);
        check("t3_fall_clr", {30'h0, i1[1], fall1[1]}, 32'h0);

        g = 4'h0;
        tick(6);
        check("settle_low", {24'h0, i0, i1}, 32'h0);

        for (int v = 0; v < 16; v++) begin
            g  = vecs[v].g;
            en = vecs[v].en;
            tick(vecs[v].hold);
            check($sformatf("vec%0d", v), {20'h0, i0, rise0, fall0},
                  {20'h0, vecs[v].exp_i, vecs[v].exp_rise, vecs[v].exp_fall});
        end

        // Staggered overlapping pulses on ch0 and ch3.
        g = 4'h1;
        tick(5);
        g = 4'h9;
        tick(9);
        check("t4_rise0", {24'h0, i0, rise0}, 32'h11);
        tick(5);
        check("t4_rise3", {24'h0, i0, rise0}, 32'h98);
        g = 4'h8;
        tick(3);
        check("t4_fall0", {24'h0, i0, fall0}, 32'h81);
        g = 4'h0;
        tick(3);
        check("t4_fall3", {24'h0, i0, fall0}, 32'h08);

        // Mid-cycle reset pulse clears outputs without a clock, then re-qualifies.
        g = 4'hF;
        tick(14);
        check("t6_pre", {24'h0, i0, rise0}, 32'hFF);
        tick(2);
        @(posedge clk11m);
        #10 rst_n = 1'b0;
        #5 check("t6_async", {20'h0, i0, rise0, fall0}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(13);
        check("t6_before", {28'h0, i0}, 32'h0);
        tick(1);
        check("t6_rise", {24'h0, i0, rise0}, 32'hFF);

        // Randomized traffic: slow toggling first so long runs qualify, then fast chatter.
        for (int n = 0; n < 3000; n++) begin
            tick(1);
            rate = (n < 1500) ? 24 : 4;
            en = ($urandom_range(0, 31) != 0);
            for (int k = 0; k < CH; k++) begin
                if ($urandom_range(0, rate - 1) == 0) g[k] = ~g[k];
            end
        end

        tick(2);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
